// File: rtl/keypad_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Brief    : Column-scanning ROWS x COLS keypad decoder. Drives one column at
//            a time, synchronises the row sense lines, debounces press and
//            release, reports a binary key code and flags multi-key columns.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int SETTLE_CYCLES   = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  localparam int CODE_W         = $clog2(ROWS * COLS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ROWS-1:0]   row_in,
  output logic [COLS-1:0]   col_drive,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_held,
  output logic              key_error
);

  localparam int c_rowIdxW = $clog2(ROWS);
  localparam int c_colIdxW = $clog2(COLS);
  localparam int c_settleW = $clog2(SETTLE_CYCLES);
  localparam int c_debW    = $clog2(DEBOUNCE_CYCLES);

  localparam logic [1:0] c_stScan     = 2'd0;
  localparam logic [1:0] c_stDebounce = 2'd1;
  localparam logic [1:0] c_stHeld     = 2'd2;

  logic [ROWS-1:0]      r_syncMeta;
  logic [ROWS-1:0]      r_syncRows;
  logic [1:0]           r_state;
  logic [1:0]           w_nextState;
  logic [c_settleW-1:0] r_settleCnt;
  logic [c_debW-1:0]    r_debCnt;
  logic [c_colIdxW-1:0] r_colIdx;
  logic [COLS-1:0]      r_colDrive;
  logic [c_rowIdxW-1:0] r_candRow;
  logic [c_rowIdxW-1:0] w_rowEnc;
  logic [CODE_W-1:0]    r_keyCode;
  logic                 r_keyValid;
  logic                 r_keyHeld;
  logic                 r_keyError;

  logic w_rowsZero;
  logic w_rowsSingle;
  logic w_candMatch;
  logic w_settleDone;
  logic w_debDone;
  logic w_capture;
  logic w_error;
  logic w_accept;
  logic w_release;
  logic w_advance;

  // All decisions are taken on the synchronised row vector r_syncRows.
  assign w_rowsZero   = ~|r_syncRows;
  assign w_rowsSingle = $onehot(r_syncRows);
  assign w_candMatch  = (r_syncRows == (ROWS'(1) << r_candRow));
  assign w_settleDone = (r_settleCnt == c_settleW'(SETTLE_CYCLES - 1));
  // The shared counter hits its limit one cycle before it would read
  // DEBOUNCE_CYCLES; the accepting/releasing cycle itself is the last count.
  assign w_debDone    = (r_debCnt == c_debW'(DEBOUNCE_CYCLES - 1));

  // Two-flop synchroniser for the asynchronous row sense lines
  always_ff @(posedge clock) begin
    if (reset) begin
      r_syncMeta <= '0;
      r_syncRows <= '0;
    end else begin
      r_syncMeta <= row_in;
      r_syncRows <= r_syncMeta;
    end
  end

  // Binary index of the (single) set row bit, used when capturing a candidate
  always_comb begin
    w_rowEnc = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (r_syncRows[i]) w_rowEnc = c_rowIdxW'(i);
    end
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) r_state <= c_stScan;
    else       r_state <= w_nextState;
  end

  // FSM next-state logic
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      c_stScan: begin
        if (w_settleDone && w_rowsSingle) w_nextState = c_stDebounce;
      end
      c_stDebounce: begin
        if (!w_candMatch)   w_nextState = c_stScan;
        else if (w_debDone) w_nextState = c_stHeld;
      end
      c_stHeld: begin
        if (w_rowsZero && w_debDone) w_nextState = c_stScan;
      end
      default: w_nextState = c_stScan;
    endcase
  end

  // FSM action decode: capture, accept, release, error and column advance
  always_comb begin
    w_capture = 1'b0;
    w_error   = 1'b0;
    w_accept  = 1'b0;
    w_release = 1'b0;
    w_advance = 1'b0;
    case (r_state)
      c_stScan: begin
        if (w_settleDone) begin
          if (w_rowsSingle) begin
            w_capture = 1'b1;
          end else begin
            w_advance = 1'b1;
            w_error   = !w_rowsZero;
          end
        end
      end
      c_stDebounce: begin
        if (!w_candMatch)   w_advance = 1'b1;
        else if (w_debDone) w_accept  = 1'b1;
      end
      c_stHeld: begin
        if (w_rowsZero && w_debDone) begin
          w_release = 1'b1;
          w_advance = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Settle counter: runs only while scanning, restarts on every new column
  always_ff @(posedge clock) begin
    if (reset)                                   r_settleCnt <= '0;
    else if (r_state == c_stScan && !w_settleDone) r_settleCnt <= r_settleCnt + c_settleW'(1);
    else                                         r_settleCnt <= '0;
  end

  // Shared press/release debounce counter; the capture sample counts as one
  always_ff @(posedge clock) begin
    if (reset)
      r_debCnt <= '0;
    else if (w_capture)
      r_debCnt <= c_debW'(1);
    else if (r_state == c_stDebounce && w_candMatch && !w_debDone)
      r_debCnt <= r_debCnt + c_debW'(1);
    else if (r_state == c_stHeld && w_rowsZero && !w_debDone)
      r_debCnt <= r_debCnt + c_debW'(1);
    else
      r_debCnt <= '0;
  end

  // Column index and one-hot drive move together, wrapping after COLS-1
  always_ff @(posedge clock) begin
    if (reset) begin
      r_colIdx   <= '0;
      r_colDrive <= COLS'(1);
    end else if (w_advance) begin
      r_colIdx   <= (r_colIdx == c_colIdxW'(COLS - 1)) ? '0 : r_colIdx + c_colIdxW'(1);
      r_colDrive <= {r_colDrive[COLS-2:0], r_colDrive[COLS-1]};
    end
  end

  // Candidate row latch; the candidate column is r_colIdx, frozen until advance
  always_ff @(posedge clock) begin
    if (reset)          r_candRow <= '0;
    else if (w_capture) r_candRow <= w_rowEnc;
  end

  // Registered key outputs: code held until next accept, pulses last one cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      r_keyCode  <= '0;
      r_keyValid <= 1'b0;
      r_keyHeld  <= 1'b0;
      r_keyError <= 1'b0;
    end else begin
      r_keyValid <= w_accept;
      r_keyError <= w_error;
      if (w_accept) begin
        r_keyCode <= CODE_W'(r_candRow) * CODE_W'(COLS) + CODE_W'(r_colIdx);
        r_keyHeld <= 1'b1;
      end else if (w_release) begin
        r_keyHeld <= 1'b0;
      end
    end
  end

  assign col_drive = r_colDrive;
  assign key_code  = r_keyCode;
  assign key_valid = r_keyValid;
  assign key_held  = r_keyHeld;
  assign key_error = r_keyError;

endmodule
`default_nettype wire

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Parametrised successor to the team's 4x4 keypad decoder. Actively scans an ROWS x COLS matrix by driving one column at a time and sampling the row lines.
- Each row line passes through a 2-flop synchroniser.
- Debounces both press and release.
- Emits a one-cycle key_valid pulse with a binary key code.
- Flags multi-key presses within a column instead of decoding them.
- Sits between the board keypad pins and the processor's input/IO register.

Parameters:
ROWS, 4, number of row sense lines (2..8)
COLS, 4, number of column drive lines (2..8)
SETTLE_CYCLES, 4, cycles each column is driven before its rows are sampled (>=3, covers synchroniser)
DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a press or a release (>=2)
CODE_W, $clog2(ROWS*COLS), key code width (derived, not overridden)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
row_in  input  ROWS  raw row sense lines, active-high, asynchronous to clock
col_drive  output  COLS  one-hot column drive, registered
key_code  output  CODE_W  row*COLS + col of last accepted key, held until next accept
key_valid  output  1  one-cycle pulse when a new key is accepted
key_held  output  1  high while the accepted key remains pressed (until release debounced)
key_error  output  1  one-cycle pulse when more than one row bit is set in the sampled column

Behaviour:
- Reset (synchronous): state=SCAN, col index=0, col_drive=1 (column 0), settle/debounce counters=0, synchroniser flops=0, key_code=0, key_valid=0, key_held=0, key_error=0. A reset mid-operation aborts any state immediately. No key_valid is emitted for a key already down at reset until it passes a full press debounce.
- rs is row_in after the 2-flop synchroniser, which adds 2 cycles of latency. All decisions use rs.
- SCAN:
  - settle counter counts 0..SETTLE_CYCLES-1 with the current column driven.
  - At count SETTLE_CYCLES-1, sample rs:
    - rs==0: advance column (wraps COLS-1 -> 0), col_drive updates next cycle, counter=0.
    - exactly one bit set: latch candidate row and col, debounce counter=1, go DEBOUNCE; column stays driven.
    - more than one bit set: key_error=1 for one cycle, advance column as for rs==0.
  - Full idle scan period = COLS*SETTLE_CYCLES cycles.
- DEBOUNCE:
  - Each cycle, rs==one-hot(candidate row): counter++.
  - Any other value: return to SCAN, advance column, no output.
  - When counter reaches DEBOUNCE_CYCLES: key_code<=row*COLS+col, key_valid=1 for exactly that one cycle, key_held<=1, go HELD.
- HELD:
  - Column stays driven; scanning is suspended.
  - Release counter increments while rs==0 and resets to 0 on any nonzero rs.
  - At DEBOUNCE_CYCLES: key_held<=0, advance column, go SCAN.
  - Extra rows appearing in HELD are ignored, with no error and no new key.
- key_code is never cleared except by reset. key_valid and key_error are never high in the same cycle.
- The same key pressed again after a debounced release produces a new key_valid. Holding a key never repeats.
- Keys in other columns pressed during HELD are not seen until the held key is released.

Test Plan:
Bench uses ROWS=4, COLS=4, SETTLE_CYCLES=4, DEBOUNCE_CYCLES=4.
1. Reset then idle (row_in=0) for 40 cycles -> col_drive cycles 0001,0010,0100,1000 each for 4 cycles, wraps to 0001; key_valid, key_error, key_held stay 0.
2. Hold row_in=0100 only while col_drive=0010 (model a key at row 2, col 1, clean) -> one key_valid pulse with key_code=9; key_held=1; col_drive frozen at 0010 until row_in=0 for 4 synchronised cycles, then key_held=0 and col_drive=0100.
3. Press row 3/col 3 with 2-cycle glitches (toggling row_in every 2 cycles) -> no key_valid. Then hold stable -> single key_valid with key_code=15.
4. row_in=0101 while col_drive=0001 -> key_error pulse, no key_valid, key_code unchanged, scan continues to 0010.
5. Assert reset while in HELD with key_held=1 -> next cycle key_held=0, col_drive=0001, key_code=0. A still-pressed key is re-accepted only after a full debounce (one new key_valid).
6. Sweep all 16 keys, each pressed and released once -> 16 key_valid pulses with key_code 0..15 in row*4+col order, no key_error.
